risc_toy_mem_arbiter: RTL and testbench

Single-port memory arbiter for the RISC_TOY core. It shares one synchronous-read SRAM (CSN/WEN active-low, 1-cycle read latency) between the instruction-fetch port and the load/store port. Data accesses have priority, and a starvation counter guarantees fetch progress. It sits between the core's IREQ/IADDR and DREQ/DRW/DADDR/DWDATA outputs and the SRAM macro, returning INSTR/DRDATA with valid strobes and per-port stall.

---
 rtl/risc_toy_pkg.sv | 37 +++
 rtl/risc_toy_arb_grant.sv | 41 ++++
 rtl/risc_toy_mem_arbiter.sv | 103 ++++++++++
 tb/tb_risc_toy_mem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: return-owner tags,
// arbiter defaults and core-wide opcode constants.
package risc_toy_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } ret_own_e;

  localparam int STARVE_MAX_DEFAULT = 3;

  localparam logic [4:0] OP_ADDI = 5'd0;
  localparam logic [4:0] OP_ANDI = 5'd1;
  localparam logic [4:0] OP_ORI  = 5'd2;
  localparam logic [4:0] OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_NEG  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd15;
  localparam logic [4:0] OP_BRL  = 5'd16;
  localparam logic [4:0] OP_J    = 5'd17;
  localparam logic [4:0] OP_JL   = 5'd18;
  localparam logic [4:0] OP_LD   = 5'd19;
  localparam logic [4:0] OP_LDR  = 5'd20;
  localparam logic [4:0] OP_ST   = 5'd21;
  localparam logic [4:0] OP_STR  = 5'd22;

endpackage

// File: rtl/risc_toy_arb_grant.sv
// Fetch/data priority decision with fetch starvation counter.
// In: clk, rst, ireq, dreq. Out: fetch_win, data_win (one-hot or none).
module risc_toy_arb_grant
  import risc_toy_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ireq,
  input  logic dreq,
  output logic fetch_win,
  output logic data_win
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic       starved;

  always_comb begin
    starved   = (starve_q == SMAX);
    fetch_win = ~rst & ireq & (~dreq | starved);
    data_win  = ~rst & dreq & ~fetch_win;
    starve_d  = 4'd0;
    // Count only cycles where fetch asked and lost.
    if (ireq && !fetch_win) begin
      starve_d = starved ? SMAX : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/risc_toy_mem_arbiter.sv
// Single-port SRAM arbiter between fetch and load/store ports.
// Ports: fetch (IREQ/IADDR/ISTALL/IVALID/INSTR), data (DREQ/DRW/DADDR/
// DWDATA/DSTALL/DVALID/DRDATA), SRAM (MCSN/MWEN/MA/MDI/MDOUT).
module risc_toy_mem_arbiter
  import risc_toy_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IREQ,
  input  logic [29:0]   IADDR,
  output logic          ISTALL,
  output logic          IVALID,
  output logic [DW-1:0] INSTR,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [29:0]   DADDR,
  input  logic [DW-1:0] DWDATA,
  output logic          DSTALL,
  output logic          DVALID,
  output logic [DW-1:0] DRDATA,
  output logic          MCSN,
  output logic          MWEN,
  output logic [AW-1:0] MA,
  output logic [DW-1:0] MDI,
  input  logic [DW-1:0] MDOUT
);

  logic          fetch_win;
  logic          data_win;
  ret_own_e      ret_own_q;
  ret_own_e      ret_own_d;
  logic [DW-1:0] instr_q;
  logic [DW-1:0] instr_d;
  logic [DW-1:0] drdata_q;
  logic [DW-1:0] drdata_d;
  logic          unused_hi;

  // Upper address bits are deliberately dropped.
  assign unused_hi = ^{IADDR[29:AW], DADDR[29:AW]};

  risc_toy_arb_grant #(
    .STARVE_MAX(STARVE_MAX)
  ) u_grant (
    .clk      (CLK),
    .rst      (RST),
    .ireq     (IREQ),
    .dreq     (DREQ),
    .fetch_win(fetch_win),
    .data_win (data_win)
  );

  always_comb begin
    MCSN      = 1'b1;
    MWEN      = 1'b1;
    MA        = '0;
    MDI       = '0;
    ret_own_d = OWN_NONE;
    unique case (1'b1)
      data_win: begin
        MCSN      = 1'b0;
        MWEN      = ~DRW;
        MA        = DADDR[AW-1:0];
        MDI       = DWDATA;
        ret_own_d = DRW ? OWN_NONE : OWN_D;
      end
      fetch_win: begin
        MCSN      = 1'b0;
        MA        = IADDR[AW-1:0];
        ret_own_d = OWN_I;
      end
      default: ;
    endcase
  end

  // Returns bypass straight from MDOUT and are held afterwards.
  always_comb begin
    ISTALL   = IREQ & ~fetch_win;
    DSTALL   = DREQ & ~data_win;
    IVALID   = (ret_own_q == OWN_I);
    DVALID   = (ret_own_q == OWN_D);
    instr_d  = IVALID ? MDOUT : instr_q;
    drdata_d = DVALID ? MDOUT : drdata_q;
    INSTR    = instr_d;
    DRDATA   = drdata_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ret_own_q <= OWN_NONE;
      instr_q   <= '0;
      drdata_q  <= '0;
    end else begin
      ret_own_q <= ret_own_d;
      instr_q   <= instr_d;
      drdata_q  <= drdata_d;
    end
  end

endmodule

// File: tb/tb_risc_toy_mem_arbiter.sv
// Directed bench for risc_toy_mem_arbiter with a
// behavioural synchronous-read SRAM.
module tb_risc_toy_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IREQ;
  logic [29:0] IADDR;
  logic        ISTALL;
  logic        IVALID;
  logic [31:0] INSTR;
  logic        DREQ;
  logic        DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;
  logic        DSTALL;
  logic        DVALID;
  logic [31:0] DRDATA;
  logic        MCSN;
  logic        MWEN;
  logic [9:0]  MA;
  logic [31:0] MDI;
  logic [31:0] MDOUT;

  logic [31:0] mem [0:1023];

  int n_chk = 0;
  int n_ok  = 0;

  always #5 CLK = ~CLK;

  risc_toy_mem_arbiter dut (
    .CLK   (CLK),
    .RST   (RST),
    .IREQ  (IREQ),
    .IADDR (IADDR),
    .ISTALL(ISTALL),
    .IVALID(IVALID),
    .INSTR (INSTR),
    .DREQ  (DREQ),
    .DRW   (DRW),
    .DADDR (DADDR),
    .DWDATA(DWDATA),
    .DSTALL(DSTALL),
    .DVALID(DVALID),
    .DRDATA(DRDATA),
    .MCSN  (MCSN),
    .MWEN  (MWEN),
    .MA    (MA),
    .MDI   (MDI),
    .MDOUT (MDOUT)
  );

  always @(posedge CLK) begin
    if (!MCSN) begin
      if (!MWEN) mem[MA] <= MDI;
      else       MDOUT   <= mem[MA];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    MDOUT  = '0;
    mem[1] = 32'h1111_0001;
    mem[2] = 32'hAAAA_0002;
    mem[3] = 32'h3333_0003;
    mem[5] = 32'h1234_5678;
    RST    = 1'b1;
    IREQ   = 1'b1;
    IADDR  = 30'd5;
    DREQ   = 1'b1;
    DRW    = 1'b0;
    DADDR  = 30'd2;
    DWDATA = '0;
    repeat (2) tick();
    #2;
    chk("rst_mcsn",   32'(MCSN),   32'd1);
    chk("rst_mwen",   32'(MWEN),   32'd1);
    chk("rst_ma",     32'(MA),     32'd0);
    chk("rst_istall", 32'(ISTALL), 32'd1);
    chk("rst_dstall", 32'(DSTALL), 32'd1);
    chk("rst_ivalid", 32'(IVALID), 32'd0);
    chk("rst_dvalid", 32'(DVALID), 32'd0);
    chk("rst_instr",  INSTR,       32'd0);

    tick();
    RST = 1'b0;
    #2;
    chk("first_dstall", 32'(DSTALL), 32'd0);
    chk("first_istall", 32'(ISTALL), 32'd1);
    chk("first_ma",     32'(MA),     32'd2);
    chk("first_mcsn",   32'(MCSN),   32'd0);
    tick();
    IREQ = 1'b0;
    DREQ = 1'b0;
    #2;
    chk("first_dvalid", 32'(DVALID), 32'd1);
    chk("first_drdata", DRDATA,      32'hAAAA_0002);
    chk("first_ivalid", 32'(IVALID), 32'd0);
    chk("idle_mcsn",    32'(MCSN),   32'd1);

    tick();
    IREQ  = 1'b1;
    IADDR = 30'd5;
    #2;
    chk("f_mcsn",   32'(MCSN),   32'd0);
    chk("f_mwen",   32'(MWEN),   32'd1);
    chk("f_ma",     32'(MA),     32'd5);
    chk("f_istall", 32'(ISTALL), 32'd0);
    tick();
    IREQ = 1'b0;
    #2;
    chk("f_ivalid", 32'(IVALID), 32'd1);
    chk("f_instr",  INSTR,       32'h1234_5678);
    tick();
    #2;
    chk("f_ivalid_off", 32'(IVALID), 32'd0);
    chk("f_instr_hold", INSTR,       32'h1234_5678);

    DREQ   = 1'b1;
    DRW    = 1'b1;
    DADDR  = 30'd8;
    DWDATA = 32'hDEAD_BEEF;
    #2;
    chk("w_mwen",   32'(MWEN),   32'd0);
    chk("w_ma",     32'(MA),     32'd8);
    chk("w_mdi",    MDI,         32'hDEAD_BEEF);
    chk("w_dstall", 32'(DSTALL), 32'd0);
    tick();
    DRW = 1'b0;
    #2;
    chk("w_no_dvalid", 32'(DVALID), 32'd0);
    chk("r_mwen",      32'(MWEN),   32'd1);
    chk("r_mcsn",      32'(MCSN),   32'd0);
    tick();
    DREQ = 1'b0;
    #2;
    chk("r_dvalid", 32'(DVALID), 32'd1);
    chk("r_drdata", DRDATA,      32'hDEAD_BEEF);

    tick();
    DREQ  = 1'b1;
    DRW   = 1'b0;
    DADDR = 30'd2;
    IREQ  = 1'b1;
    IADDR = 30'd5;
    for (int i = 0; i < 12; i++) begin
      #2;
      chk($sformatf("sv_istall%0d", i), 32'(ISTALL),
          (i % 4 == 3) ? 32'd0 : 32'd1);
      chk($sformatf("sv_dstall%0d", i), 32'(DSTALL),
          (i % 4 == 3) ? 32'd1 : 32'd0);
      chk($sformatf("sv_ma%0d", i), 32'(MA),
          (i % 4 == 3) ? 32'd5 : 32'd2);
      tick();
    end
    IREQ = 1'b0;
    DREQ = 1'b0;
    tick();

    IREQ  = 1'b1;
    IADDR = 30'd1;
    #2;
    chk("alt_ma1", 32'(MA), 32'd1);
    tick();
    IREQ  = 1'b0;
    DREQ  = 1'b1;
    DADDR = 30'd2;
    #2;
    chk("alt_iv1",   32'(IVALID), 32'd1);
    chk("alt_dv1",   32'(DVALID), 32'd0);
    chk("alt_instr1", INSTR,      32'h1111_0001);
    chk("alt_ma2",   32'(MA),     32'd2);
    tick();
    DREQ  = 1'b0;
    IREQ  = 1'b1;
    IADDR = 30'd3;
    #2;
    chk("alt_dv2",    32'(DVALID), 32'd1);
    chk("alt_iv2",    32'(IVALID), 32'd0);
    chk("alt_drdata", DRDATA,      32'hAAAA_0002);
    tick();
    IREQ = 1'b0;
    #2;
    chk("alt_iv3",    32'(IVALID), 32'd1);
    chk("alt_dv3",    32'(DVALID), 32'd0);
    chk("alt_instr3", INSTR,       32'h3333_0003);
    tick();

    IREQ  = 1'b1;
    IADDR = 30'h0000_0C05;
    #2;
    chk("hi_addr_ma", 32'(MA), 32'd5);
    tick();
    RST  = 1'b1;
    IREQ = 1'b0;
    #2;
    chk("mrst_ivalid", 32'(IVALID), 32'd0);
    chk("mrst_instr",  INSTR,       32'd0);
    tick();
    RST = 1'b0;
    #2;
    chk("post_ivalid", 32'(IVALID), 32'd0);
    chk("post_instr",  INSTR,       32'd0);
    chk("post_mcsn",   32'(MCSN),   32'd1);
    tick();

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
